// File: rtl/rnn_pkg.sv
// Shared definitions for the recurrent-cell scheduler.
// Contents:
//   - DATA_W_DEF: the default width of data and state.
//   - sched_st_e: states of the output-register FSM.
//   - clog2_safe: ceil(log2(n)), never less than 1, so a port is always at least 1 bit wide.
package rnn_pkg;

  localparam int DATA_W_DEF = 8;

  typedef enum logic {
    SCHED_IDLE = 1'b0,  // output register empty
    SCHED_FULL = 1'b1   // output register holds a result
  } sched_st_e;

  function automatic int clog2_safe(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < n) r = i + 1;
    return (n <= 2) ? 1 : r;
  endfunction

endpackage

// File: rtl/rnn_rr_arbiter.sv
// Combinational round-robin arbiter.
// Searches req upward from ptr, wrapping at NUM_CH, and grants the first set bit.
// Ports:
//   req      requests, one per channel
//   en       enables the grant; when low, no grant is issued
//   ptr      channel with highest priority in this cycle
//   gnt      one-hot grant
//   gnt_idx  binary index of the granted channel (0 when there is no grant)
module rnn_rr_arbiter
  import rnn_pkg::*;
#(
  parameter int NUM_CH = 4,
  localparam int IW    = clog2_safe(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic              en,
  input  logic [IW-1:0]     ptr,
  output logic [NUM_CH-1:0] gnt,
  output logic [IW-1:0]     gnt_idx
);

  always_comb begin
    int  idx;
    logic found;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = (int'(ptr) + i) % NUM_CH;
      if (en && !found && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_idx  = IW'(idx);
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rnn_seq_sched.sv
// Shares one accumulate cell (state + current, wrapping) among NUM_CH streams.
// Each cycle a round-robin arbiter picks one requester. Its updated state goes to a
// single-entry output register with a valid/ready handshake.
// On the SEQ_LEN-th step of a sequence, out_last is set and that channel's state is cleared.
// Ports:
//   clk, rst_n  clock; asynchronous active-low reset
//   in_valid    per-channel request
//   in_data     per-channel operand; channel i is at [i*DATA_W +: DATA_W]
//   in_ready    one-hot grant
//   clr         per-channel synchronous clear of state and step counter
//   out_valid   handshake for the output register
//   out_ready   handshake for the output register
//   out_data    updated hidden state
//   out_ch      channel that produced out_data
//   out_last    set when the result is the last step of its sequence
module rnn_seq_sched
  import rnn_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int SEQ_LEN = 4,
  localparam int IW     = clog2_safe(NUM_CH),
  localparam int CW     = clog2_safe(SEQ_LEN + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH-1:0]        in_valid,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  output logic [NUM_CH-1:0]        in_ready,
  input  logic [NUM_CH-1:0]        clr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [IW-1:0]            out_ch,
  output logic                     out_last
);

  sched_st_e                        st;
  logic [IW-1:0]                    ptr;
  logic [NUM_CH-1:0][DATA_W-1:0]    state_q;
  logic [NUM_CH-1:0][CW-1:0]        cnt_q;
  logic [NUM_CH-1:0][DATA_W-1:0]    din;

  logic              slot_free, accept, is_last;
  logic [NUM_CH-1:0] gnt;
  logic [IW-1:0]     g;
  logic [DATA_W-1:0] src, sum;
  logic [CW-1:0]     cnt_next;

  assign din = in_data;

  // The slot can be refilled in the same cycle that the consumer drains it.
  assign slot_free = (st == SCHED_IDLE) || out_ready;

  rnn_rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .req     (in_valid),
    .en      (slot_free),
    .ptr     (ptr),
    .gnt     (gnt),
    .gnt_idx (g)
  );

  assign in_ready = gnt;
  assign accept   = |gnt;

  // A clear arriving with the accept takes effect first: start from zero.
  assign src      = clr[g] ? '0 : state_q[g];
  assign sum      = src + din[g];
  assign cnt_next = (clr[g] ? '0 : cnt_q[g]) + 1'b1;
  assign is_last  = (cnt_next == CW'(SEQ_LEN));

  // Per-channel state and step-counter banks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= '0;
      cnt_q   <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (accept && g == IW'(i)) begin
          state_q[i] <= is_last ? '0 : sum;
          cnt_q[i]   <= is_last ? '0 : cnt_next;
        end else if (clr[i]) begin
          state_q[i] <= '0;
          cnt_q[i]   <= '0;
        end
      end
    end
  end

  // Output-register FSM, the round-robin pointer, and the registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= SCHED_IDLE;
      ptr       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      out_last  <= 1'b0;
    end else begin
      if (accept) begin
        ptr       <= (int'(g) == NUM_CH - 1) ? '0 : g + 1'b1;
        out_valid <= 1'b1;
        out_data  <= sum;
        out_ch    <= g;
        out_last  <= is_last;
      end
      case (st)
        SCHED_IDLE: if (accept) st <= SCHED_FULL;
        SCHED_FULL: if (out_ready && !accept) begin
          st        <= SCHED_IDLE;
          out_valid <= 1'b0;
        end
        default: st <= SCHED_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rnn_seq_sched.sv
// Directed testbench for rnn_seq_sched with hand-computed expected values.
// u_dut uses the default parameters. u_dut1 uses SEQ_LEN=1.
module tb_rnn_seq_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  in_valid = '0, in_ready, clr = '0;
  logic [31:0] in_data = '0;
  logic        out_valid, out_ready = 1'b1, out_last;
  logic [7:0]  out_data;
  logic [1:0]  out_ch;

  logic [3:0]  in_valid1 = '0, in_ready1;
  logic [31:0] in_data1 = '0;
  logic        out_valid1, out_last1;
  logic [7:0]  out_data1;
  logic [1:0]  out_ch1;

  int n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;

  rnn_seq_sched #(.NUM_CH(4), .DATA_W(8), .SEQ_LEN(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .clr(clr), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ch(out_ch), .out_last(out_last)
  );

  rnn_seq_sched #(.NUM_CH(4), .DATA_W(8), .SEQ_LEN(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_data(in_data1),
    .in_ready(in_ready1), .clr(4'b0000), .out_valid(out_valid1), .out_ready(1'b1),
    .out_data(out_data1), .out_ch(out_ch1), .out_last(out_last1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = '0; clr = '0; out_ready = 1'b1;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic chk_out(input string tag, input logic [7:0] d, input logic [1:0] ch,
                         input logic last);
    chk({tag, "_vld"},  32'(out_valid), 32'd1);
    chk({tag, "_data"}, 32'(out_data),  32'(d));
    chk({tag, "_ch"},   32'(out_ch),    32'(ch));
    chk({tag, "_last"}, 32'(out_last),  32'(last));
  endtask

  logic [7:0] t1_in   [5] = '{8'd3, 8'd5, 8'd7, 8'd9, 8'd1};
  logic [7:0] t1_exp  [5] = '{8'd3, 8'd8, 8'd15, 8'd24, 8'd1};
  logic       t1_last [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

  initial begin
    // Reset state
    do_reset();
    #1;
    chk("rst_vld",  32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data),  32'd0);
    chk("rst_ch",   32'(out_ch),    32'd0);
    chk("rst_last", 32'(out_last),  32'd0);
    chk("rst_rdy",  32'(in_ready),  32'd0);

    // Test 1: single channel, back-to-back
    for (int k = 0; k < 5; k++) begin
      in_valid = 4'b0001;
      in_data[7:0] = t1_in[k];
      #1 chk("t1_rdy", 32'(in_ready), 32'd1);
      tick();
      chk_out("t1", t1_exp[k], 2'd0, t1_last[k]);
    end
    in_valid = '0;
    tick();
    chk("t1_drain", 32'(out_valid), 32'd0);

    // Test 2: round-robin over all four channels
    do_reset();
    in_valid = 4'b1111;
    in_data  = 32'h4030_2010;
    for (int k = 0; k < 8; k++) begin
      #1 chk("t2_rdy", 32'(in_ready), 32'(1 << (k % 4)));
      tick();
      chk_out("t2", 8'((16 * ((k % 4) + 1)) * ((k / 4) + 1)), 2'(k % 4), 1'b0);
    end
    in_valid = '0;

    // Test 3: backpressure
    do_reset();
    out_ready = 1'b0;
    in_valid  = 4'b0010;
    in_data   = 32'h0007_2200;
    #1 chk("t3_rdy0", 32'(in_ready), 32'b0010);
    tick();
    in_valid = 4'b0100;
    for (int k = 0; k < 3; k++) begin
      #1 chk("t3_hold_rdy", 32'(in_ready), 32'd0);
      chk_out("t3_hold", 8'h22, 2'd1, 1'b0);
      tick();
    end
    out_ready = 1'b1;
    #1 chk("t3_rdy2", 32'(in_ready), 32'b0100);
    tick();
    chk_out("t3_ch2", 8'h07, 2'd2, 1'b0);
    in_valid = '0;
    tick();
    chk("t3_drain", 32'(out_valid), 32'd0);

    // Test 4: wrap, then clear together with an accept
    do_reset();
    in_valid = 4'b1000;
    in_data[31:24] = 8'hF0; tick(); chk_out("t4_a", 8'hF0, 2'd3, 1'b0);
    in_data[31:24] = 8'h20; tick(); chk_out("t4_wrap", 8'h10, 2'd3, 1'b0);
    clr = 4'b1000;
    in_data[31:24] = 8'h05; tick(); chk_out("t4_clr", 8'h05, 2'd3, 1'b0);
    clr = '0;
    in_data[31:24] = 8'h01; tick(); chk_out("t4_s2", 8'h06, 2'd3, 1'b0);
    tick(); chk_out("t4_s3", 8'h07, 2'd3, 1'b0);
    tick(); chk_out("t4_s4", 8'h08, 2'd3, 1'b1);
    // A clear without an accept resets the channel and leaves the held result unchanged.
    in_valid = '0; out_ready = 1'b0;
    in_data[31:24] = 8'h09; tick();
    clr = 4'b1000; tick(); clr = '0;
    chk_out("t4_hold", 8'h08, 2'd3, 1'b1);
    out_ready = 1'b1; in_valid = 4'b1000;
    tick(); chk_out("t4_clr2", 8'h09, 2'd3, 1'b0);
    in_valid = '0;

    // Test 5: reset in the middle of a sequence
    do_reset();
    in_valid = 4'b0001;
    in_data[7:0] = 8'h01;
    tick(); tick();
    chk_out("t5_pre", 8'h02, 2'd0, 1'b0);
    in_valid = '0;
    rst_n = 1'b0;
    #1 chk("t5_async", 32'(out_valid), 32'd0);
    tick();
    rst_n = 1'b1;
    in_valid = 4'b0001;
    in_data[7:0] = 8'h04;
    tick(); chk_out("t5_s1", 8'h04, 2'd0, 1'b0);
    tick(); chk_out("t5_s2", 8'h08, 2'd0, 1'b0);
    tick(); chk_out("t5_s3", 8'h0C, 2'd0, 1'b0);
    tick(); chk_out("t5_s4", 8'h10, 2'd0, 1'b1);
    in_valid = '0;

    // Test 6: SEQ_LEN=1, so every result is last and equals the input
    in_valid1 = 4'b0101;
    in_data1  = 32'h0033_0011;
    tick();
    chk("t6_d0",  32'(out_data1),  32'h11);
    chk("t6_c0",  32'(out_ch1),    32'd0);
    chk("t6_l0",  32'(out_last1),  32'd1);
    tick();
    chk("t6_d1",  32'(out_data1),  32'h33);
    chk("t6_c1",  32'(out_ch1),    32'd2);
    chk("t6_l1",  32'(out_last1),  32'd1);
    tick();
    chk("t6_d2",  32'(out_data1),  32'h11);
    chk("t6_l2",  32'(out_last1),  32'd1);
    chk("t6_v2",  32'(out_valid1), 32'd1);
    in_valid1 = '0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
